// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0..T2, opcode-dependent execute T3..T7, HALT.
// All strobes are flops fed from the next-state decode, so ir never reaches an output directly.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    output logic        pco,
    output logic        pci,
    output logic        pc_inc,
    output logic        iri,
    output logic        mari,
    output logic        mdri,
    output logic        mdro,
    output logic        mem_read,
    output logic        mem_write,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        ryi,
    output logic        rzli,
    output logic        rzlo,
    output logic        csigno,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  t_state
);

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT2    = 4'd3,
        StT3    = 4'd4,
        StT4    = 4'd5,
        StT5    = 4'd6,
        StT6    = 4'd7,
        StT7    = 4'd8,
        StHalt  = 4'd15
    } state_e;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef struct packed {
        logic pco;
        logic pci;
        logic pc_inc;
        logic iri;
        logic mari;
        logic mdri;
        logic mdro;
        logic mem_read;
        logic mem_write;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
        logic ryi;
        logic rzli;
        logic rzlo;
        logic csigno;
    } strobe_t;

    state_e     state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    strobe_t    strb_q, strb_d;
    logic [4:0] alu_op_q, alu_op_d;
    logic       run_q, run_d;

    // Only the opcode field of ir is consumed here.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    // Next-state and opcode latch; opcode only moves on the T2->T3 step.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            StT2: begin
                state_d  = StT3;
                opcode_d = ir[31:27];
            end
            StT3: begin
                case (opcode_q)
                    OpLd, OpSt, OpLdi, OpAdd, OpAddi: state_d = StT4;
                    OpHalt:                           state_d = StHalt;
                    default:                          state_d = StT0;
                endcase
            end
            StT4:    state_d = StT5;
            StT5: begin
                case (opcode_q)
                    OpLd, OpSt: state_d = StT6;
                    default:    state_d = StT0;
                endcase
            end
            StT6:    state_d = StT7;
            StT7:    state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    // Strobe decode of the upcoming step, registered below.
    always_comb begin
        strb_d   = '0;
        alu_op_d = 5'd0;
        run_d    = 1'b1;
        case (state_d)
            StT0: begin
                strb_d.pco    = 1'b1;
                strb_d.mari   = 1'b1;
                strb_d.pc_inc = 1'b1;
            end
            StT1: begin
                strb_d.mem_read = 1'b1;
                strb_d.mdri     = 1'b1;
            end
            StT2: begin
                strb_d.mdro = 1'b1;
                strb_d.iri  = 1'b1;
            end
            StT3: begin
                alu_op_d = opcode_d;
                case (opcode_d)
                    OpLd, OpSt, OpLdi: begin
                        strb_d.grb   = 1'b1;
                        strb_d.baout = 1'b1;
                        strb_d.ryi   = 1'b1;
                    end
                    OpAdd, OpAddi: begin
                        strb_d.grb  = 1'b1;
                        strb_d.rout = 1'b1;
                        strb_d.ryi  = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                alu_op_d = opcode_d;
                strb_d.rzli = 1'b1;
                if (opcode_d == OpAdd) begin
                    strb_d.grc  = 1'b1;
                    strb_d.rout = 1'b1;
                end else begin
                    strb_d.csigno = 1'b1;
                end
            end
            StT5: begin
                alu_op_d = opcode_d;
                strb_d.rzlo = 1'b1;
                if (opcode_d == OpLd || opcode_d == OpSt) begin
                    strb_d.mari = 1'b1;
                end else begin
                    strb_d.gra = 1'b1;
                    strb_d.rin = 1'b1;
                end
            end
            StT6: begin
                alu_op_d = opcode_d;
                strb_d.mdri = 1'b1;
                if (opcode_d == OpSt) begin
                    strb_d.gra  = 1'b1;
                    strb_d.rout = 1'b1;
                end else begin
                    strb_d.mem_read = 1'b1;
                end
            end
            StT7: begin
                alu_op_d = opcode_d;
                if (opcode_d == OpSt) begin
                    strb_d.mem_write = 1'b1;
                end else begin
                    strb_d.mdro = 1'b1;
                    strb_d.gra  = 1'b1;
                    strb_d.rin  = 1'b1;
                end
            end
            StHalt:  run_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= StReset;
            opcode_q <= OpNop;
            strb_q   <= '0;
            alu_op_q <= 5'd0;
            run_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            strb_q   <= strb_d;
            alu_op_q <= alu_op_d;
            run_q    <= run_d;
        end
    end

    assign pco       = strb_q.pco;
    assign pci       = strb_q.pci;
    assign pc_inc    = strb_q.pc_inc;
    assign iri       = strb_q.iri;
    assign mari      = strb_q.mari;
    assign mdri      = strb_q.mdri;
    assign mdro      = strb_q.mdro;
    assign mem_read  = strb_q.mem_read;
    assign mem_write = strb_q.mem_write;
    assign gra       = strb_q.gra;
    assign grb       = strb_q.grb;
    assign grc       = strb_q.grc;
    assign rin       = strb_q.rin;
    assign rout      = strb_q.rout;
    assign baout     = strb_q.baout;
    assign ryi       = strb_q.ryi;
    assign rzli      = strb_q.rzli;
    assign rzlo      = strb_q.rzlo;
    assign csigno    = strb_q.csigno;
    assign alu_op    = alu_op_q;
    assign run       = run_q;
    assign t_state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks every opcode step by step against
// hand-written strobe masks, plus mid-instruction reset and HALT hold.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic pco, pci, pc_inc, iri, mari, mdri, mdro, mem_read, mem_write;
    logic gra, grb, grc, rin, rout, baout, ryi, rzli, rzlo, csigno;
    logic [4:0] alu_op;
    logic       run;
    logic [3:0] t_state;

    int checks = 0;
    int errors = 0;

    // Strobe bit positions in the packed observation vector.
    localparam logic [18:0] CSIGNO = 19'd1 << 0;
    localparam logic [18:0] RZLO   = 19'd1 << 1;
    localparam logic [18:0] RZLI   = 19'd1 << 2;
    localparam logic [18:0] RYI    = 19'd1 << 3;
    localparam logic [18:0] BAOUT  = 19'd1 << 4;
    localparam logic [18:0] ROUT   = 19'd1 << 5;
    localparam logic [18:0] RIN    = 19'd1 << 6;
    localparam logic [18:0] GRC    = 19'd1 << 7;
    localparam logic [18:0] GRB    = 19'd1 << 8;
    localparam logic [18:0] GRA    = 19'd1 << 9;
    localparam logic [18:0] MWR    = 19'd1 << 10;
    localparam logic [18:0] MRD    = 19'd1 << 11;
    localparam logic [18:0] MDRO   = 19'd1 << 12;
    localparam logic [18:0] MDRI   = 19'd1 << 13;
    localparam logic [18:0] MARI   = 19'd1 << 14;
    localparam logic [18:0] IRI    = 19'd1 << 15;
    localparam logic [18:0] PCINC  = 19'd1 << 16;
    localparam logic [18:0] PCI    = 19'd1 << 17;
    localparam logic [18:0] PCO    = 19'd1 << 18;
    localparam logic [18:0] NONE   = 19'd0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir),
        .pco(pco), .pci(pci), .pc_inc(pc_inc), .iri(iri), .mari(mari), .mdri(mdri),
        .mdro(mdro), .mem_read(mem_read), .mem_write(mem_write),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
        .ryi(ryi), .rzli(rzli), .rzlo(rzlo), .csigno(csigno),
        .alu_op(alu_op), .run(run), .t_state(t_state)
    );

    always #5 clock = ~clock;

    function automatic logic [18:0] strobes();
        return {pco, pci, pc_inc, iri, mari, mdri, mdro, mem_read, mem_write,
                gra, grb, grc, rin, rout, baout, ryi, rzli, rzlo, csigno};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the current step's outputs, then advances one clock.
    task automatic step(input string tag, input logic [3:0] t, input logic [18:0] s,
                        input logic [4:0] op, input logic r);
        chk({tag, " t_state"}, 32'(t_state), 32'(t));
        chk({tag, " strobes"}, 32'(strobes()), 32'(s));
        chk({tag, " alu_op"}, 32'(alu_op), 32'(op));
        chk({tag, " run"}, 32'(run), 32'(r));
        tick();
    endtask

    task automatic fetch(input string tag);
        step({tag, " T0"}, 4'd1, PCO | MARI | PCINC, 5'd0, 1'b1);
        step({tag, " T1"}, 4'd2, MRD | MDRI, 5'd0, 1'b1);
        step({tag, " T2"}, 4'd3, MDRO | IRI, 5'd0, 1'b1);
    endtask

    initial begin
        clear = 1'b1;
        ir    = {5'b00010, 27'h0123456};
        tick();
        tick();
        // Reset state after two clear cycles
        step("reset", 4'd0, NONE, 5'd0, 1'b1);
        clear = 1'b0;
        // The check above ticked with clear still high; take one more reset cycle.
        step("reset2", 4'd0, NONE, 5'd0, 1'b1);

        // st, with ir switched to addi during T4
        fetch("st");
        step("st T3", 4'd4, GRB | BAOUT | RYI, 5'b00010, 1'b1);
        ir = {5'b01100, 27'h7654321};
        step("st T4", 4'd5, CSIGNO | RZLI, 5'b00010, 1'b1);
        step("st T5", 4'd6, RZLO | MARI, 5'b00010, 1'b1);
        step("st T6", 4'd7, GRA | ROUT | MDRI, 5'b00010, 1'b1);
        step("st T7", 4'd8, MWR, 5'b00010, 1'b1);

        ir = {5'b00000, 27'h0000abc};
        fetch("ld");
        step("ld T3", 4'd4, GRB | BAOUT | RYI, 5'b00000, 1'b1);
        step("ld T4", 4'd5, CSIGNO | RZLI, 5'b00000, 1'b1);
        step("ld T5", 4'd6, RZLO | MARI, 5'b00000, 1'b1);
        step("ld T6", 4'd7, MRD | MDRI, 5'b00000, 1'b1);
        step("ld T7", 4'd8, MDRO | GRA | RIN, 5'b00000, 1'b1);

        ir = {5'b00011, 27'h1111111};
        fetch("add");
        step("add T3", 4'd4, GRB | ROUT | RYI, 5'b00011, 1'b1);
        step("add T4", 4'd5, GRC | ROUT | RZLI, 5'b00011, 1'b1);
        step("add T5", 4'd6, RZLO | GRA | RIN, 5'b00011, 1'b1);

        ir = {5'b00001, 27'h2222222};
        fetch("ldi");
        step("ldi T3", 4'd4, GRB | BAOUT | RYI, 5'b00001, 1'b1);
        step("ldi T4", 4'd5, CSIGNO | RZLI, 5'b00001, 1'b1);
        step("ldi T5", 4'd6, RZLO | GRA | RIN, 5'b00001, 1'b1);

        ir = {5'b01100, 27'h3333333};
        fetch("addi");
        step("addi T3", 4'd4, GRB | ROUT | RYI, 5'b01100, 1'b1);
        step("addi T4", 4'd5, CSIGNO | RZLI, 5'b01100, 1'b1);
        step("addi T5", 4'd6, RZLO | GRA | RIN, 5'b01100, 1'b1);

        ir = {5'b11010, 27'h0};
        fetch("nop");
        step("nop T3", 4'd4, NONE, 5'b11010, 1'b1);

        ir = {5'b11111, 27'h5555555};
        fetch("undef");
        step("undef T3", 4'd4, NONE, 5'b11111, 1'b1);

        // ld interrupted by clear in T5
        ir = {5'b00000, 27'h0000def};
        fetch("ldrst");
        step("ldrst T3", 4'd4, GRB | BAOUT | RYI, 5'b00000, 1'b1);
        step("ldrst T4", 4'd5, CSIGNO | RZLI, 5'b00000, 1'b1);
        clear = 1'b1;
        step("ldrst T5", 4'd6, RZLO | MARI, 5'b00000, 1'b1);
        clear = 1'b0;
        step("ldrst RESET", 4'd0, NONE, 5'd0, 1'b1);

        ir = {5'b11011, 27'h0};
        fetch("halt");
        step("halt T3", 4'd4, NONE, 5'b11011, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halt hold %0d", i), 4'd15, NONE, 5'd0, 1'b0);
        end
        clear = 1'b1;
        step("halt last", 4'd15, NONE, 5'd0, 1'b0);
        clear = 1'b0;
        step("halt RESET", 4'd0, NONE, 5'd0, 1'b1);
        ir = {5'b11010, 27'h0};
        fetch("post-halt");
        step("post-halt T3", 4'd4, NONE, 5'b11010, 1'b1);
        step("post-halt T0", 4'd1, PCO | MARI | PCINC, 5'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port ir, input, 32 bits: instruction register contents from datapath; opcode is ir[31:27].
REQ-004 SHALL have outputs pco, pci, pc_inc, iri, mari, mdri, mdro, mem_read, mem_write, 1 bit each: datapath PC/IR/MAR/MDR/memory strobes.
REQ-005 SHALL have outputs gra, grb, grc, rin, rout, baout, 1 bit each: register-file select/enable strobes.
REQ-006 SHALL have outputs ryi, rzli, rzlo, csigno, 1 bit each: ALU operand/result and sign-extended constant strobes.
REQ-007 SHALL have output alu_op, 5 bits: equals ir[31:27] during execute steps, 0 otherwise.
REQ-008 SHALL have output run, 1 bit: high while sequencing, low in HALT.
REQ-009 SHALL have output t_state, 4 bits: current step encoding for debug (RESET=0, T0..T7=1..8, HALT=15).

Function
REQ-010 SHALL be a Moore FSM; every strobe SHALL be decoded from the state register and latched opcode only, with no combinational path from ir to any strobe.
REQ-011 SHALL use opcodes: ld=00000, ldi=00001, st=00010, add=00011, addi=01100, nop=11010, halt=11011; any other opcode SHALL execute as nop.
REQ-012 SHALL latch ir[31:27] into an internal opcode register on the T2->T3 transition, and SHALL hold it constant through T3..T7.
REQ-013 SHALL sequence RESET->T0 unconditionally.
REQ-014 SHALL perform fetch in three steps:
- T0: pco, mari, pc_inc.
- T1: mem_read, mdri.
- T2: mdro, iri.
REQ-015 SHALL execute st as:
- T3: grb, baout, ryi.
- T4: csigno, rzli.
- T5: rzlo, mari.
- T6: gra, rout, mdri.
- T7: mem_write.
- Then T0.
REQ-016 SHALL execute ld as:
- T3: grb, baout, ryi.
- T4: csigno, rzli.
- T5: rzlo, mari.
- T6: mem_read, mdri.
- T7: mdro, gra, rin.
- Then T0.
REQ-017 SHALL execute ldi as:
- T3: grb, baout, ryi.
- T4: csigno, rzli.
- T5: rzlo, gra, rin.
- Then T0.
REQ-018 SHALL execute addi as:
- T3: grb, rout, ryi.
- T4: csigno, rzli.
- T5: rzlo, gra, rin.
- Then T0.
REQ-019 SHALL execute add as:
- T3: grb, rout, ryi.
- T4: grc, rout, rzli.
- T5: rzlo, gra, rin.
- Then T0.
REQ-020 SHALL go from T3 to T0 for nop and undefined opcodes, asserting no strobe in T3.
REQ-021 SHALL go from T3 to HALT for halt; HALT SHALL drive all strobes low and run low, and SHALL remain in HALT until clear.
REQ-022 SHALL never assert mem_read and mem_write in the same cycle, and SHALL assert at most one of gra/grb/grc per cycle.
REQ-023 SHALL never assert both rout and baout in the same cycle.
REQ-024 SHALL assert each strobe for exactly one clock cycle per step, with no step longer than one cycle.
REQ-025 SHALL give instruction latency, from T0 entry to the next T0 entry: ld/st 8 cycles, ldi/addi/add 6 cycles, nop 4 cycles.

Reset
REQ-026 SHALL enter RESET on any rising edge with clear=1, from any state including mid-execute and HALT.
REQ-027 SHALL, in RESET, drive all strobes 0, alu_op=0, run=1, t_state=0, and opcode register=nop.
REQ-028 SHALL enter T0 on the first rising edge with clear=0 after reset.
REQ-029 SHALL discard a partially executed instruction on reset, with no further strobes for it.

Verification
REQ-030 SHALL be verified: clear=1 for 2 cycles, then low -> t_state 0 then 1; pco, mari and pc_inc high for exactly one cycle.
REQ-031 SHALL be verified: ir=st (opcode 00010) -> over T3..T7, strobes exactly as in REQ-015; mem_write high only in T7; next T0 at cycle 8.
REQ-032 SHALL be verified: ir=ld -> T6 mem_read and mdri high; T7 mdro, gra and rin high; mem_write never high.
REQ-033 SHALL be verified: ir=add -> T4 grc, rout and rzli high; alu_op=00011 during T3..T5; return to T0 after T5.
REQ-034 SHALL be verified: ir changes to addi during T4 of an st -> st sequence is unaffected.
REQ-035 SHALL be verified: reset during T5 of an ld -> state goes to RESET, then T0, with no mem_read in between.
REQ-036 SHALL be verified: ir=halt -> run=0 and t_state=15 held for 20 cycles; clear -> T0.
REQ-037 SHALL be verified: ir=11111 -> behaves as nop, 4-cycle loop.
